// File: rtl/counter_updown_bounded_pkg.sv
// Shared definitions for the bounded up/down counter: next-state select encoding
// and the helper that picks the landing bound on an overflow or underflow.
package counter_updown_bounded_pkg;

  typedef logic [2:0] next_sel_t;

  localparam next_sel_t SEL_HOLD   = 3'd0;
  localparam next_sel_t SEL_LOAD   = 3'd1;
  localparam next_sel_t SEL_STEP   = 3'd2;
  localparam next_sel_t SEL_TO_MIN = 3'd3;
  localparam next_sel_t SEL_TO_MAX = 3'd4;

  // Saturation stays on the bound that was crossed; wrap lands on the opposite one.
  function automatic next_sel_t bound_sel(input logic sat, input logic crossed_max);
    if (sat == crossed_max) begin
      return SEL_TO_MAX;
    end
    return SEL_TO_MIN;
  endfunction

endpackage

// File: rtl/counter_updown_bounded_next_calc.sv
// Combinational step evaluation for the bounded counter: decides whether a step
// stays in range, overflows or underflows, and produces the resulting count.
module counter_next_calc
  import counter_updown_bounded_pkg::*;
#(
  parameter int N      = 8,
  parameter int STEP_W = 4
) (
  input  logic [N-1:0]      count_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [N-1:0]      min_i,
  input  logic [N-1:0]      max_i,
  input  logic              up_i,
  input  logic              sat_i,
  output logic [N-1:0]      next_count_o,
  output next_sel_t         sel_o,
  output logic              ovf_evt_o,
  output logic              unf_evt_o
);

  logic [N:0]   step_w;
  logic [N-1:0] step_n;
  logic [N:0]   sum_w;
  logic [N:0]   min_plus_step_w;
  logic [N-1:0] count_up;
  logic [N-1:0] count_dn;

  // Compares are done one bit wider so count+step never rolls back into range.
  assign step_w          = {{(N+1-STEP_W){1'b0}}, step_i};
  assign step_n          = {{(N-STEP_W){1'b0}}, step_i};
  assign sum_w           = {1'b0, count_i} + step_w;
  assign min_plus_step_w = {1'b0, min_i} + step_w;
  assign count_up        = count_i + step_n;
  assign count_dn        = count_i - step_n;

  always_comb begin
    sel_o     = SEL_HOLD;
    ovf_evt_o = 1'b0;
    unf_evt_o = 1'b0;
    if (step_i != '0) begin
      if (up_i) begin
        if (sum_w <= {1'b0, max_i}) begin
          sel_o = SEL_STEP;
        end else begin
          sel_o     = bound_sel(sat_i, 1'b1);
          ovf_evt_o = 1'b1;
        end
      end else begin
        if ({1'b0, count_i} >= min_plus_step_w) begin
          sel_o = SEL_STEP;
        end else begin
          sel_o     = bound_sel(sat_i, 1'b0);
          unf_evt_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_count_o = count_i;
    case (sel_o)
      SEL_STEP:   next_count_o = up_i ? count_up : count_dn;
      SEL_TO_MIN: next_count_o = min_i;
      SEL_TO_MAX: next_count_o = max_i;
      default:    next_count_o = count_i;
    endcase
  end

endmodule

// File: rtl/counter_updown_bounded.sv
// Bounded up/down counter with programmable step, wrap/saturate handling,
// single-cycle overflow/underflow pulses and clearable sticky flags.
module counter_updown_bounded
  import counter_updown_bounded_pkg::*;
#(
  parameter int           N       = 8,
  parameter int           STEP_W  = 4,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [N-1:0]      load_val_i,
  input  logic              en_i,
  input  logic              up_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [N-1:0]      min_i,
  input  logic [N-1:0]      max_i,
  input  logic              sat_i,
  input  logic              clr_flags_i,
  output logic [N-1:0]      count_o,
  output logic              at_max_o,
  output logic              at_min_o,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              ovf_sticky_o,
  output logic              unf_sticky_o,
  output logic              cfg_err_o
);

  logic [N-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         ovf_sticky_q, ovf_sticky_d;
  logic         unf_sticky_q, unf_sticky_d;

  logic [N-1:0] calc_next;
  next_sel_t    calc_sel;
  next_sel_t    sel;
  logic         calc_ovf;
  logic         calc_unf;
  logic         step_ok;

  counter_next_calc #(
    .N      (N),
    .STEP_W (STEP_W)
  ) u_next_calc (
    .count_i      (count_q),
    .step_i       (step_i),
    .min_i        (min_i),
    .max_i        (max_i),
    .up_i         (up_i),
    .sat_i        (sat_i),
    .next_count_o (calc_next),
    .sel_o        (calc_sel),
    .ovf_evt_o    (calc_ovf),
    .unf_evt_o    (calc_unf)
  );

  assign cfg_err_o = (min_i > max_i);
  assign step_ok   = en_i && !cfg_err_o;

  always_comb begin
    sel = SEL_HOLD;
    if (load_i) begin
      sel = SEL_LOAD;
    end else if (step_ok) begin
      sel = calc_sel;
    end
  end

  // Sticky set has priority over clear when both happen on the same edge.
  always_comb begin
    count_d = count_q;
    case (sel)
      SEL_HOLD: count_d = count_q;
      SEL_LOAD: count_d = load_val_i;
      default:  count_d = calc_next;
    endcase
    ovf_d        = !load_i && step_ok && calc_ovf;
    unf_d        = !load_i && step_ok && calc_unf;
    ovf_sticky_d = ovf_d || (ovf_sticky_q && !clr_flags_i);
    unf_sticky_d = unf_d || (unf_sticky_q && !clr_flags_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= RST_VAL;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  assign count_o      = count_q;
  assign ovf_o        = ovf_q;
  assign unf_o        = unf_q;
  assign ovf_sticky_o = ovf_sticky_q;
  assign unf_sticky_o = unf_sticky_q;
  assign at_max_o     = (count_q == max_i);
  assign at_min_o     = (count_q == min_i);

endmodule

// File: tb/tb_counter_updown_bounded.sv
// Scoreboard bench for counter_updown_bounded: a behavioural model queues the
// expected outputs for each driven cycle, and each test task pops and compares them.
module tb_counter_updown_bounded;

  localparam int         N       = 8;
  localparam int         STEP_W  = 4;
  localparam logic [7:0] RST_VAL = 8'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_i = 1'b0;
  logic [7:0]  load_val_i = '0;
  logic        en_i = 1'b0;
  logic        up_i = 1'b0;
  logic [3:0]  step_i = '0;
  logic [7:0]  min_i = '0;
  logic [7:0]  max_i = '0;
  logic        sat_i = 1'b0;
  logic        clr_flags_i = 1'b0;
  logic [7:0]  count_o;
  logic        at_max_o, at_min_o, ovf_o, unf_o;
  logic        ovf_sticky_o, unf_sticky_o, cfg_err_o;

  // Expected DUT outputs after one driven cycle.
  typedef struct packed {
    logic [7:0] count;
    logic       atMax;
    logic       atMin;
    logic       ovf;
    logic       unf;
    logic       ovfS;
    logic       unfS;
    logic       cfgErr;
  } obs_t;

  obs_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   mCount = 0;
  bit   mOvfS = 1'b0;
  bit   mUnfS = 1'b0;

  always #5 clk = ~clk;

  counter_updown_bounded #(
    .N       (N),
    .STEP_W  (STEP_W),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_i),
    .load_val_i   (load_val_i),
    .en_i         (en_i),
    .up_i         (up_i),
    .step_i       (step_i),
    .min_i        (min_i),
    .max_i        (max_i),
    .sat_i        (sat_i),
    .clr_flags_i  (clr_flags_i),
    .count_o      (count_o),
    .at_max_o     (at_max_o),
    .at_min_o     (at_min_o),
    .ovf_o        (ovf_o),
    .unf_o        (unf_o),
    .ovf_sticky_o (ovf_sticky_o),
    .unf_sticky_o (unf_sticky_o),
    .cfg_err_o    (cfg_err_o)
  );

  function automatic obs_t sampleDut();
    obs_t o;
    o = '{count_o, at_max_o, at_min_o, ovf_o, unf_o, ovf_sticky_o, unf_sticky_o, cfg_err_o};
    return o;
  endfunction

  // Drives one cycle, predicts the outcome with wide integer arithmetic and
  // queues it, then returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input bit r, input bit ld, input int lv, input bit en,
                               input bit up, input int st, input int mn, input int mx,
                               input bit sat, input bit clr);
    obs_t e;
    bit   ovf, unf;
    rst = r; load_i = ld; load_val_i = lv[7:0]; en_i = en; up_i = up;
    step_i = st[3:0]; min_i = mn[7:0]; max_i = mx[7:0]; sat_i = sat; clr_flags_i = clr;
    ovf = 1'b0;
    unf = 1'b0;
    if (r) begin
      mCount = int'(RST_VAL);
      mOvfS  = 1'b0;
      mUnfS  = 1'b0;
    end else begin
      if (ld) begin
        mCount = lv;
      end else if (en && !(mn > mx) && st != 0) begin
        if (up) begin
          if (mCount + st <= mx) mCount = mCount + st;
          else begin ovf = 1'b1; mCount = sat ? mx : mn; end
        end else begin
          if (mCount >= mn + st) mCount = mCount - st;
          else begin unf = 1'b1; mCount = sat ? mn : mx; end
        end
      end
      mOvfS = ovf || (mOvfS && !clr);
      mUnfS = unf || (mUnfS && !clr);
    end
    e.count  = mCount[7:0];
    e.atMax  = (mCount == mx);
    e.atMin  = (mCount == mn);
    e.ovf    = ovf;
    e.unf    = unf;
    e.ovfS   = mOvfS;
    e.unfS   = mUnfS;
    e.cfgErr = (mn > mx);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = expQ.pop_front(); o = sampleDut(); checks++;
    if (o !== e) $display("[TB] FAIL reset_sb: got %0d/%b expected %0d/%b", o.count, o[6:0], e.count, e[6:0]);
    else passes++;
    checks++;
    if (count_o !== 8'd5 || ovf_o !== 1'b0 || unf_o !== 1'b0 || ovf_sticky_o !== 1'b0 || unf_sticky_o !== 1'b0)
      $display("[TB] FAIL reset_val: got count=%0d flags=%b%b%b%b expected count=5 flags=0000",
               count_o, ovf_o, unf_o, ovf_sticky_o, unf_sticky_o);
    else passes++;
    applyStimulus(0, 1, 200, 0, 0, 0, 0, 255, 0, 0);
    e = expQ.pop_front(); o = sampleDut(); checks++;
    if (o !== e) $display("[TB] FAIL load_sb: got %0d/%b expected %0d/%b", o.count, o[6:0], e.count, e[6:0]);
    else passes++;
    checks++;
    if (count_o !== 8'd200 || ovf_o !== 1'b0)
      $display("[TB] FAIL load_200: got count=%0d ovf=%b expected count=200 ovf=0", count_o, ovf_o);
    else passes++;
  endtask

  task automatic test_wrap_up();
    obs_t e, o;
    int   seq [3] = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, seq[i] == 0, 18, seq[i] == 1, 1, 3, 10, 20, 0, 0);
      e = expQ.pop_front(); o = sampleDut(); checks++;
      if (o !== e) $display("[TB] FAIL wrap_up_%0d: got %0d/%b expected %0d/%b", i, o.count, o[6:0], e.count, e[6:0]);
      else passes++;
      if (i == 1) begin
        checks++;
        if (count_o !== 8'd10 || ovf_o !== 1'b1 || ovf_sticky_o !== 1'b1)
          $display("[TB] FAIL wrap_to_min: got count=%0d ovf=%b sticky=%b expected 10/1/1", count_o, ovf_o, ovf_sticky_o);
        else passes++;
      end
    end
  endtask

  task automatic test_sat_down();
    obs_t e, o;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, i == 0, 12, i inside {[1:3]}, 0, 4, 10, 20, 1, i >= 3);
      e = expQ.pop_front(); o = sampleDut(); checks++;
      if (o !== e) $display("[TB] FAIL sat_down_%0d: got %0d/%b expected %0d/%b", i, o.count, o[6:0], e.count, e[6:0]);
      else passes++;
      if (i == 3) begin
        checks++;
        if (count_o !== 8'd10 || unf_o !== 1'b1 || unf_sticky_o !== 1'b1 || ovf_sticky_o !== 1'b0)
          $display("[TB] FAIL set_beats_clr: got count=%0d unf=%b usticky=%b osticky=%b expected 10/1/1/0",
                   count_o, unf_o, unf_sticky_o, ovf_sticky_o);
        else passes++;
      end
    end
  endtask

  task automatic test_full_range();
    obs_t e, o;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, i == 0, 255, i == 1, 1, 1, 0, 255, 0, 0);
      e = expQ.pop_front(); o = sampleDut(); checks++;
      if (o !== e) $display("[TB] FAIL full_range_%0d: got %0d/%b expected %0d/%b", i, o.count, o[6:0], e.count, e[6:0]);
      else passes++;
    end
    checks++;
    if (count_o !== 8'd0 || ovf_o !== 1'b1)
      $display("[TB] FAIL wrap_255: got count=%0d ovf=%b expected 0/1", count_o, ovf_o);
    else passes++;
  endtask

  task automatic test_cfg_err();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, i == 3, 7, i < 3, i != 1, 2, 30, 20, i[0], 0);
      e = expQ.pop_front(); o = sampleDut(); checks++;
      if (o !== e) $display("[TB] FAIL cfg_err_%0d: got %0d/%b expected %0d/%b", i, o.count, o[6:0], e.count, e[6:0]);
      else passes++;
    end
    checks++;
    if (count_o !== 8'd7 || cfg_err_o !== 1'b1)
      $display("[TB] FAIL cfg_err_load: got count=%0d cfg_err=%b expected 7/1", count_o, cfg_err_o);
    else passes++;
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    applyStimulus(0, 1, 50, 1, 1, 1, 0, 255, 0, 0);
    e = expQ.pop_front(); o = sampleDut(); checks++;
    if (o !== e || count_o !== 8'd50)
      $display("[TB] FAIL load_wins: got %0d/%b expected %0d/%b", o.count, o[6:0], e.count, e[6:0]);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i == 2, 0, 0, 1, 1, 5, 0, 60, 0, 0);
      e = expQ.pop_front(); o = sampleDut(); checks++;
      if (o !== e) $display("[TB] FAIL count_rst_%0d: got %0d/%b expected %0d/%b", i, o.count, o[6:0], e.count, e[6:0]);
      else passes++;
    end
    for (int i = 0; i < 80; i++) begin
      int mn, mx;
      mn = $urandom_range(0, 120);
      mx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(mn, 255);
      applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 255),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 15),
                    mn, mx, $urandom_range(0, 1), $urandom_range(0, 5) == 0);
      e = expQ.pop_front(); o = sampleDut(); checks++;
      if (o !== e) $display("[TB] FAIL random_%0d: got %0d/%b expected %0d/%b", i, o.count, o[6:0], e.count, e[6:0]);
      else passes++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_full_range();
    test_cfg_err();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got %0d/%0d checks", passes, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
